teclado_cajero: RTL and testbench

TECLADO_CAJERO -- requirements
Module: teclado_cajero

---
 rtl/teclado_cajero.sv | 212 +++++++++++++++++++++
 tb/tb_teclado_cajero.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/teclado_cajero.sv
// -----------------------------------------------------------------------------
// teclado_cajero
//
// Purpose:
//   This is the keypad front-end for an ATM.
//   - While a card is present, it forwards up to four PIN digits to the
//     controller, one strobe per digit.
//   - It waits for the controller to accept or reject the PIN.
//   - After that it builds a 32-bit binary amount from decimal key presses.
//   - The amount goes to the controller on ENTER.
//   - The block then waits for the controller to finish the transaction.
//
// Ports:
//   clk                   in   system clock, rising edge
//   reset                 in   asynchronous active-high reset
//   tarjeta_recibida      in   card present (session active while high)
//   tecla[3:0]            in   key code: 0-9 digit, 10 ENTER, 11 BORRAR
//   tecla_stb             in   one-cycle strobe qualifying tecla
//   pin_incorrecto        in   controller: wrong PIN
//   bloqueo               in   controller: card blocked
//   balance_actualizado   in   controller: deposit done
//   entregar_dinero       in   controller: withdrawal done
//   fondos_insuficientes  in   controller: withdrawal refused
//   digito[3:0]           out  PIN digit to the controller
//   digito_stb            out  one-cycle strobe qualifying digito
//   monto[31:0]           out  binary amount to the controller
//   monto_stb             out  one-cycle strobe qualifying monto
//   desborde              out  one-cycle pulse, amount digit rejected
// -----------------------------------------------------------------------------
module teclado_cajero (
  input  logic        clk,
  input  logic        reset,
  input  logic        tarjeta_recibida,
  input  logic [3:0]  tecla,
  input  logic        tecla_stb,
  input  logic        pin_incorrecto,
  input  logic        bloqueo,
  input  logic        balance_actualizado,
  input  logic        entregar_dinero,
  input  logic        fondos_insuficientes,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        desborde
);

  typedef enum logic [2:0] {
    INICIO     = 3'd0,
    PIN        = 3'd1,
    ESPERA_PIN = 3'd2,
    MONTO      = 3'd3,
    ESPERA_FIN = 3'd4
  } state_t;

  localparam logic [3:0] KEY_ENTER  = 4'd10;
  localparam logic [3:0] KEY_BORRAR = 4'd11;

  state_t      r_state;
  logic [2:0]  r_count;
  logic [31:0] r_acc;
  logic        r_has_digit;
  logic [3:0]  r_digito;
  logic        r_digito_stb;
  logic [31:0] r_monto;
  logic        r_monto_stb;
  logic        r_desborde;

  state_t      w_state_next;
  logic [2:0]  w_count_next;
  logic [31:0] w_acc_next;
  logic        w_has_digit_next;
  logic [3:0]  w_digito_next;
  logic        w_digito_stb_next;
  logic [31:0] w_monto_next;
  logic        w_monto_stb_next;
  logic        w_desborde_next;

  logic        w_es_digito;
  logic        w_es_enter;
  logic        w_es_borrar;
  logic        w_abort;
  logic        w_fin;
  logic [35:0] w_acc_x10;
  logic        w_overflow;

  assign w_es_digito = tecla_stb && (tecla <= 4'd9);
  assign w_es_enter  = tecla_stb && (tecla == KEY_ENTER);
  assign w_es_borrar = tecla_stb && (tecla == KEY_BORRAR);
  assign w_abort     = bloqueo || !tarjeta_recibida;
  assign w_fin       = balance_actualizado || entregar_dinero || fondos_insuficientes;

  // The worst case is (2^32-1)*10+9, which fits in 36 bits.
  // A value in bits [35:32] means the new amount does not fit in 32 bits.
  assign w_acc_x10  = {4'b0000, r_acc} * 36'd10 + {32'd0, tecla};
  assign w_overflow = |w_acc_x10[35:32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= INICIO;
      r_count      <= 3'd0;
      r_acc        <= 32'd0;
      r_has_digit  <= 1'b0;
      r_digito     <= 4'd0;
      r_digito_stb <= 1'b0;
      r_monto      <= 32'd0;
      r_monto_stb  <= 1'b0;
      r_desborde   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_count      <= w_count_next;
      r_acc        <= w_acc_next;
      r_has_digit  <= w_has_digit_next;
      r_digito     <= w_digito_next;
      r_digito_stb <= w_digito_stb_next;
      r_monto      <= w_monto_next;
      r_monto_stb  <= w_monto_stb_next;
      r_desborde   <= w_desborde_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_count_next      = r_count;
    w_acc_next        = r_acc;
    w_has_digit_next  = r_has_digit;
    w_digito_next     = r_digito;
    w_monto_next      = r_monto;
    w_digito_stb_next = 1'b0;
    w_monto_stb_next  = 1'b0;
    w_desborde_next   = 1'b0;

    // Losing the card or being blocked overrides any key in the same cycle.
    if (w_abort) begin
      w_state_next     = INICIO;
      w_count_next     = 3'd0;
      w_acc_next       = 32'd0;
      w_has_digit_next = 1'b0;
    end else begin
      case (r_state)
        INICIO: begin
          // The card is present here, because w_abort is low.
          w_state_next     = PIN;
          w_count_next     = 3'd0;
          w_acc_next       = 32'd0;
          w_has_digit_next = 1'b0;
        end

        PIN: begin
          if (w_es_digito) begin
            w_digito_next     = tecla;
            w_digito_stb_next = 1'b1;
            w_count_next      = r_count + 3'd1;
            if (r_count == 3'd3) begin
              w_state_next = ESPERA_PIN;
            end
          end
        end

        ESPERA_PIN: begin
          // A wrong-PIN indication wins over a key in the same cycle.
          if (pin_incorrecto) begin
            w_state_next = PIN;
            w_count_next = 3'd0;
          end else if (w_es_digito) begin
            // The first amount digit is the key that leaves this state.
            w_state_next     = MONTO;
            w_acc_next       = {28'd0, tecla};
            w_has_digit_next = 1'b1;
          end
        end

        MONTO: begin
          if (w_es_digito) begin
            if (w_overflow) begin
              w_desborde_next = 1'b1;
            end else begin
              w_acc_next       = w_acc_x10[31:0];
              w_has_digit_next = 1'b1;
            end
          end else if (w_es_borrar) begin
            w_acc_next       = 32'd0;
            w_has_digit_next = 1'b0;
          end else if (w_es_enter && r_has_digit) begin
            w_monto_next     = r_acc;
            w_monto_stb_next = 1'b1;
            w_state_next     = ESPERA_FIN;
          end
        end

        ESPERA_FIN: begin
          if (w_fin) begin
            w_state_next     = INICIO;
            w_acc_next       = 32'd0;
            w_has_digit_next = 1'b0;
          end
        end

        default: begin
          w_state_next = INICIO;
        end
      endcase
    end
  end

  assign digito     = r_digito;
  assign digito_stb = r_digito_stb;
  assign monto      = r_monto;
  assign monto_stb  = r_monto_stb;
  assign desborde   = r_desborde;

endmodule

// File: tb/tb_teclado_cajero.sv
// -----------------------------------------------------------------------------
// tb_teclado_cajero
//
// Purpose:
//   Self-checking bench for teclado_cajero.
//   - A table of single-cycle vectors covers the PIN entry, a full amount
//     session and the key-precedence rules.
//   - Hand-written sequences cover amount overflow, BORRAR/ENTER handling,
//     card removal and an asynchronous reset mid-session.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_teclado_cajero;

  logic        clk;
  logic        reset;
  logic        tarjeta_recibida;
  logic [3:0]  tecla;
  logic        tecla_stb;
  logic        pin_incorrecto;
  logic        bloqueo;
  logic        balance_actualizado;
  logic        entregar_dinero;
  logic        fondos_insuficientes;
  logic [3:0]  digito;
  logic        digito_stb;
  logic [31:0] monto;
  logic        monto_stb;
  logic        desborde;

  int n_cmp = 0;
  int n_err = 0;

  teclado_cajero dut (
    .clk                  (clk),
    .reset                (reset),
    .tarjeta_recibida     (tarjeta_recibida),
    .tecla                (tecla),
    .tecla_stb            (tecla_stb),
    .pin_incorrecto       (pin_incorrecto),
    .bloqueo              (bloqueo),
    .balance_actualizado  (balance_actualizado),
    .entregar_dinero      (entregar_dinero),
    .fondos_insuficientes (fondos_insuficientes),
    .digito               (digito),
    .digito_stb           (digito_stb),
    .monto                (monto),
    .monto_stb            (monto_stb),
    .desborde             (desborde)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State encodings of the design's FSM.
  localparam logic [2:0] S_INICIO = 3'd0;
  localparam logic [2:0] S_PIN    = 3'd1;
  localparam logic [2:0] S_EPIN   = 3'd2;
  localparam logic [2:0] S_MONTO  = 3'd3;
  localparam logic [2:0] S_EFIN   = 3'd4;

  typedef struct {
    logic        tarj;
    logic        stb;
    logic [3:0]  key;
    logic        pinc;
    logic        blq;
    logic [2:0]  fin;     // {fondos, entregar, balance}
    logic [2:0]  e_state;
    logic        e_dstb;
    logic [3:0]  e_dig;
    logic        e_mstb;
    logic [31:0] e_monto;
    logic        e_desb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic tarj, input logic stb, input logic [3:0] key,
                     input logic pinc, input logic blq, input logic [2:0] fin,
                     input logic [2:0] e_state, input logic e_dstb, input logic [3:0] e_dig,
                     input logic e_mstb, input logic [31:0] e_monto, input logic e_desb);
    vec_t v;
    v.tarj = tarj; v.stb = stb; v.key = key; v.pinc = pinc; v.blq = blq; v.fin = fin;
    v.e_state = e_state; v.e_dstb = e_dstb; v.e_dig = e_dig;
    v.e_mstb = e_mstb; v.e_monto = e_monto; v.e_desb = e_desb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    tecla     = k;
    tecla_stb = 1'b1;
    tick();
    tecla_stb = 1'b0;
  endtask

  // Force INICIO, insert the card and send the PIN 3,4,4,3.
  task automatic enter_session();
    tarjeta_recibida = 1'b0;
    tick();
    tarjeta_recibida = 1'b1;
    tick();
    key(4'd3); key(4'd4); key(4'd4); key(4'd3);
  endtask

  // At most one of the three strobes may be high in any cycle.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if ((32'(digito_stb) + 32'(monto_stb) + 32'(desborde)) > 32'd1) begin
        n_err++;
        $display("FAIL onehot: stb=%b%b%b required at most one", digito_stb, monto_stb, desborde);
      end
    end
  end

  initial begin
    reset = 1'b1; tarjeta_recibida = 1'b0; tecla = 4'd0; tecla_stb = 1'b0;
    pin_incorrecto = 1'b0; bloqueo = 1'b0; balance_actualizado = 1'b0;
    entregar_dinero = 1'b0; fondos_insuficientes = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst state", 32'(dut.r_state), 32'(S_INICIO));
    chk("rst digito", 32'(digito), 32'd0);
    chk("rst dstb", 32'(digito_stb), 32'd0);
    chk("rst monto", monto, 32'd0);
    chk("rst mstb", 32'(monto_stb), 32'd0);
    chk("rst desborde", 32'(desborde), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle no card", 32'(dut.r_state), 32'(S_INICIO));

    // ---------------- table: PIN, amount 100, wrong PIN, precedence ----------------
    //  tarj stb key  pinc blq fin     state    dstb dig mstb monto desb
    add(1, 0, 4'd0,  0, 0, 3'b000, S_PIN,    0, 4'd0, 0, 32'd0,   0);
    add(1, 1, 4'd3,  0, 0, 3'b000, S_PIN,    1, 4'd3, 0, 32'd0,   0);
    add(1, 1, 4'd4,  0, 0, 3'b000, S_PIN,    1, 4'd4, 0, 32'd0,   0);
    add(1, 1, 4'd10, 0, 0, 3'b000, S_PIN,    0, 4'd4, 0, 32'd0,   0);
    add(1, 1, 4'd4,  0, 0, 3'b000, S_PIN,    1, 4'd4, 0, 32'd0,   0);
    add(1, 1, 4'd3,  0, 0, 3'b000, S_EPIN,   1, 4'd3, 0, 32'd0,   0);
    add(1, 0, 4'd0,  0, 0, 3'b000, S_EPIN,   0, 4'd3, 0, 32'd0,   0);
    add(1, 1, 4'd1,  0, 0, 3'b000, S_MONTO,  0, 4'd3, 0, 32'd0,   0);
    add(1, 1, 4'd0,  0, 0, 3'b000, S_MONTO,  0, 4'd3, 0, 32'd0,   0);
    add(1, 1, 4'd0,  0, 0, 3'b000, S_MONTO,  0, 4'd3, 0, 32'd0,   0);
    add(1, 1, 4'd10, 0, 0, 3'b000, S_EFIN,   0, 4'd3, 1, 32'd100, 0);
    add(1, 1, 4'd5,  0, 0, 3'b000, S_EFIN,   0, 4'd3, 0, 32'd100, 0);
    add(1, 0, 4'd0,  0, 0, 3'b001, S_INICIO, 0, 4'd3, 0, 32'd100, 0);
    add(1, 0, 4'd0,  0, 0, 3'b000, S_PIN,    0, 4'd3, 0, 32'd100, 0);
    add(1, 1, 4'd1,  0, 0, 3'b000, S_PIN,    1, 4'd1, 0, 32'd100, 0);
    add(1, 1, 4'd2,  0, 0, 3'b000, S_PIN,    1, 4'd2, 0, 32'd100, 0);
    add(1, 1, 4'd3,  0, 0, 3'b000, S_PIN,    1, 4'd3, 0, 32'd100, 0);
    add(1, 1, 4'd4,  0, 0, 3'b000, S_EPIN,   1, 4'd4, 0, 32'd100, 0);
    add(1, 1, 4'd7,  1, 0, 3'b000, S_PIN,    0, 4'd4, 0, 32'd100, 0);
    add(1, 1, 4'd3,  0, 0, 3'b000, S_PIN,    1, 4'd3, 0, 32'd100, 0);
    add(1, 1, 4'd4,  0, 0, 3'b000, S_PIN,    1, 4'd4, 0, 32'd100, 0);
    add(1, 1, 4'd4,  0, 0, 3'b000, S_PIN,    1, 4'd4, 0, 32'd100, 0);
    add(1, 1, 4'd3,  0, 0, 3'b000, S_EPIN,   1, 4'd3, 0, 32'd100, 0);
    add(1, 1, 4'd12, 0, 0, 3'b000, S_EPIN,   0, 4'd3, 0, 32'd100, 0);
    add(1, 1, 4'd9,  0, 0, 3'b000, S_MONTO,  0, 4'd3, 0, 32'd100, 0);
    add(1, 1, 4'd5,  0, 1, 3'b000, S_INICIO, 0, 4'd3, 0, 32'd100, 0);
    add(1, 0, 4'd0,  0, 0, 3'b000, S_PIN,    0, 4'd3, 0, 32'd100, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      tarjeta_recibida     = vecs[i].tarj;
      tecla                = vecs[i].key;
      tecla_stb            = vecs[i].stb;
      pin_incorrecto       = vecs[i].pinc;
      bloqueo              = vecs[i].blq;
      balance_actualizado  = vecs[i].fin[0];
      entregar_dinero      = vecs[i].fin[1];
      fondos_insuficientes = vecs[i].fin[2];
      tick();
      chk($sformatf("v%0d state", i), 32'(dut.r_state), 32'(vecs[i].e_state));
      chk($sformatf("v%0d dstb", i), 32'(digito_stb), 32'(vecs[i].e_dstb));
      chk($sformatf("v%0d digito", i), 32'(digito), 32'(vecs[i].e_dig));
      chk($sformatf("v%0d mstb", i), 32'(monto_stb), 32'(vecs[i].e_mstb));
      chk($sformatf("v%0d monto", i), monto, vecs[i].e_monto);
      chk($sformatf("v%0d desborde", i), 32'(desborde), 32'(vecs[i].e_desb));
      tecla_stb = 1'b0; pin_incorrecto = 1'b0; bloqueo = 1'b0;
      balance_actualizado = 1'b0; entregar_dinero = 1'b0; fondos_insuficientes = 1'b0;
    end

    // ---------------- overflow boundary ----------------
    enter_session();
    key(4'd4); key(4'd2); key(4'd9); key(4'd4); key(4'd9);
    key(4'd6); key(4'd7); key(4'd2); key(4'd9);
    chk("ovf acc 429496729", dut.r_acc, 32'd429496729);
    key(4'd6);  // 4294967296 does not fit
    chk("ovf 6 desborde", 32'(desborde), 32'd1);
    chk("ovf 6 acc kept", dut.r_acc, 32'd429496729);
    key(4'd5);  // 4294967295 fits exactly
    chk("ovf 5 desborde", 32'(desborde), 32'd0);
    chk("ovf acc max", dut.r_acc, 32'hFFFF_FFFF);
    key(4'd0);
    chk("ovf 0 desborde", 32'(desborde), 32'd1);
    chk("ovf 0 dstb", 32'(digito_stb), 32'd0);
    chk("ovf 0 acc kept", dut.r_acc, 32'hFFFF_FFFF);
    tick();
    chk("ovf pulse ends", 32'(desborde), 32'd0);
    key(4'd10);
    chk("ovf enter mstb", 32'(monto_stb), 32'd1);
    chk("ovf enter monto", monto, 32'hFFFF_FFFF);
    tick();
    chk("ovf mstb single", 32'(monto_stb), 32'd0);
    entregar_dinero = 1'b1;
    tick();
    entregar_dinero = 1'b0;
    chk("ovf fin state", 32'(dut.r_state), 32'(S_INICIO));

    // ---------------- BORRAR then empty ENTER ----------------
    enter_session();
    key(4'd5);
    key(4'd11);
    chk("borrar acc", dut.r_acc, 32'd0);
    key(4'd10);
    chk("empty enter mstb", 32'(monto_stb), 32'd0);
    chk("empty enter state", 32'(dut.r_state), 32'(S_MONTO));
    key(4'd7);
    key(4'd10);
    chk("enter 7 mstb", 32'(monto_stb), 32'd1);
    chk("enter 7 monto", monto, 32'd7);
    fondos_insuficientes = 1'b1;
    tick();
    fondos_insuficientes = 1'b0;
    chk("fondos state", 32'(dut.r_state), 32'(S_INICIO));

    // ---------------- card removed mid-amount ----------------
    enter_session();
    key(4'd1); key(4'd2);
    chk("pre-drop acc", dut.r_acc, 32'd12);
    tarjeta_recibida = 1'b0;
    tecla = 4'd10; tecla_stb = 1'b1;   // ENTER in the same cycle loses to the abort
    tick();
    tecla_stb = 1'b0;
    chk("drop state", 32'(dut.r_state), 32'(S_INICIO));
    chk("drop mstb", 32'(monto_stb), 32'd0);
    chk("drop acc", dut.r_acc, 32'd0);
    chk("drop monto held", monto, 32'd7);
    tick();
    chk("drop stays", 32'(dut.r_state), 32'(S_INICIO));

    // ---------------- asynchronous reset mid-amount ----------------
    enter_session();
    key(4'd1); key(4'd2);
    #2;
    reset = 1'b1;
    #1;  // still before the next rising edge
    chk("arst state", 32'(dut.r_state), 32'(S_INICIO));
    chk("arst digito", 32'(digito), 32'd0);
    chk("arst monto", monto, 32'd0);
    chk("arst acc", dut.r_acc, 32'd0);
    chk("arst strobes", {29'd0, digito_stb, monto_stb, desborde}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post-rst state", 32'(dut.r_state), 32'(S_PIN));
    chk("post-rst mstb", 32'(monto_stb), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
